dm_bus_arbiter: RTL and testbench
=================================

Name: dm_bus_arbiter

Overview:
- Shares one system-bus master port (req/gnt/r_valid protocol) between NrPorts requesters.
- Port 0 is the debug module's SBA master; the other ports are, e.g., a core data port or a DMA.
- Uses round-robin arbitration with request locking, so the address stays stable until grant.
- Tracks outstanding transactions in an in-order ID FIFO and routes each read response back to its issuer.

Parameters:
NrPorts, 2, number of requesters (>=2)
BusWidth, 32, address/data width (32 or 64)
MaxOutstanding, 2, max granted-but-unanswered transactions (>=1)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
req_i  input  NrPorts  per-port request
add_i  input  NrPorts x BusWidth  per-port address
we_i  input  NrPorts  per-port write enable
wdata_i  input  NrPorts x BusWidth  per-port write data
be_i  input  NrPorts x BusWidth/8  per-port byte enables
gnt_o  output  NrPorts  per-port grant (one-hot or zero)
r_valid_o  output  NrPorts  per-port response valid (one-hot or zero)
r_rdata_o  output  BusWidth  response data, broadcast to all ports
master_req_o  output  1  bus request
master_add_o  output  BusWidth  bus address
master_we_o  output  1  bus write enable
master_wdata_o  output  BusWidth  bus write data
master_be_o  output  BusWidth/8  bus byte enables
master_gnt_i  input  1  bus grant
master_r_valid_i  input  1  bus response valid (reads and writes both respond)
master_r_rdata_i  input  BusWidth  bus response data

Behaviour:
- Clock/reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - round-robin pointer = 0;
  - lock flag clear;
  - FIFO empty (count = 0).
- Requester protocol: a requester holds req and its address/data/be stable until it sees gnt_o. A transfer completes in a cycle where master_req_o && master_gnt_i.
- Arbitration (combinational selection, registered state):
  - If the lock flag is set, the selected port is the locked port.
  - Otherwise, the selected port is the first asserted req_i at or after rr_ptr, wrapping modulo NrPorts.
- Master side:
  - master_req_o = selected port valid && FIFO not full.
  - Master address/we/wdata/be mux from the selected port.
  - All master data outputs are 0 when master_req_o is low.
- Grant and lock:
  - gnt_o[sel] = master_req_o && master_gnt_i; zero latency (combinational pass-through).
  - Lock: if master_req_o && !master_gnt_i, set the lock to sel next cycle.
  - Clear the lock on the grant cycle.
  - A locked port's req must not drop; if it drops, clear the lock and flag it (assertion, not RTL behaviour).
- Pointer update: on a grant, rr_ptr <= (sel+1) mod NrPorts. No change otherwise.
- ID FIFO:
  - Depth MaxOutstanding; entries are port IDs, width max(1,$clog2(NrPorts)); count width $clog2(MaxOutstanding+1).
  - Push sel on a grant.
  - Pop the head on master_r_valid_i.
  - r_valid_o[head] = master_r_valid_i; r_rdata_o = master_r_rdata_i (same cycle, no register).
  - Bus responses are in order; at most one response per cycle.
- Boundaries:
  - Full: master_req_o forced low even if a requester is pending. The lock flag is unaffected, and gnt_o stays 0.
  - Full plus a response in the same cycle: the pop frees the slot next cycle only. The request is not issued in the full cycle; no bypass.
  - Simultaneous push and pop when not full: count unchanged; both pointers advance, wrapping at MaxOutstanding.
  - Response with FIFO empty: r_valid_o all 0, response dropped, assertion fires.
  - Grant with FIFO full cannot occur, since master_req_o is low.
  - Reset mid-operation: FIFO and lock are discarded immediately. Late bus responses after reset are dropped as empty-FIFO responses; the system must reset the bus together with the arbiter.
- Assertions (non-synthesis): gnt_o and r_valid_o are onehot0; no FIFO overflow; the BusWidth check.

Test Plan:
- Single requester: port1 req, add=0x1000, we=0, gnt the same cycle -> gnt_o=2'b10 in cycle 0; r_valid_i in cycle 2 with 0xDEADBEEF -> r_valid_o=2'b10, r_rdata_o=0xDEADBEEF.
- Round-robin: both ports request continuously, gnt held 1, responses 1 cycle later -> grants alternate 0,1,0,1; responses routed in issue order.
- Lock: port0 requests, master_gnt_i low 3 cycles, port1 raises req in cycle 1 -> master_add_o stays port0's address for 4 cycles; port0 granted in cycle 3; port1 granted in cycle 4.
- Backpressure (MaxOutstanding=2): two grants with no responses -> master_req_o=0 while port1 req is pending; response in cycle N -> master_req_o=1 in cycle N+1.
- Simultaneous grant and response at count=1 -> count stays 1; correct head routed; next response goes to the newly pushed port.
- Reset asserted with 2 outstanding and locked -> all outputs 0 asynchronously; after release, port0 request granted first (rr_ptr=0); stray r_valid produces no r_valid_o.

Source files
------------

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: round-robin system-bus arbiter with request locking and in-order response routing
module dm_bus_arbiter #(
  parameter int NrPorts        = 2,
  parameter int BusWidth       = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrPorts-1:0]            req_i,
  input  logic [NrPorts*BusWidth-1:0]   add_i,
  input  logic [NrPorts-1:0]            we_i,
  input  logic [NrPorts*BusWidth-1:0]   wdata_i,
  input  logic [NrPorts*BusWidth/8-1:0] be_i,
  output logic [NrPorts-1:0]            gnt_o,
  output logic [NrPorts-1:0]            r_valid_o,
  output logic [BusWidth-1:0]           r_rdata_o,
  output logic                          master_req_o,
  output logic [BusWidth-1:0]           master_add_o,
  output logic                          master_we_o,
  output logic [BusWidth-1:0]           master_wdata_o,
  output logic [BusWidth/8-1:0]         master_be_o,
  input  logic                          master_gnt_i,
  input  logic                          master_r_valid_i,
  input  logic [BusWidth-1:0]           master_r_rdata_i
);
  localparam int IdW  = (NrPorts > 2) ? $clog2(NrPorts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int BeW  = BusWidth / 8;

  logic [IdW-1:0]  r_rr_ptr, r_lock_port, w_sel, w_head;
  logic            r_lock;
  logic [IdW-1:0]  r_ids [MaxOutstanding];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  logic            w_sel_valid, w_full, w_issue, w_fire, w_pop;

  function automatic logic [IdW-1:0] wrap_port(input int v);
    return IdW'((v >= NrPorts) ? v - NrPorts : v);
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (int'(p) == MaxOutstanding - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_sel       = r_lock_port;
    w_sel_valid = 1'b0;
    if (r_lock) w_sel_valid = req_i[r_lock_port];
    else for (int i = NrPorts - 1; i >= 0; i--) begin
      if (req_i[wrap_port(int'(r_rr_ptr) + i)]) begin
        w_sel       = wrap_port(int'(r_rr_ptr) + i);
        w_sel_valid = 1'b1;
      end
    end
  end

  assign w_full  = r_count == CntW'(MaxOutstanding);
  assign w_issue = w_sel_valid && !w_full;
  assign w_fire  = w_issue && master_gnt_i;
  assign w_pop   = master_r_valid_i && (r_count != '0);
  assign w_head  = r_ids[r_rptr];

  assign master_req_o   = rst_ni && w_issue;
  assign gnt_o          = (rst_ni && w_fire) ? NrPorts'(1) << w_sel : '0;
  assign r_valid_o      = (rst_ni && w_pop) ? NrPorts'(1) << w_head : '0;
  assign r_rdata_o      = rst_ni ? master_r_rdata_i : '0;
  assign master_add_o   = master_req_o ? add_i[int'(w_sel)*BusWidth +: BusWidth] : '0;
  assign master_we_o    = master_req_o && we_i[w_sel];
  assign master_wdata_o = master_req_o ? wdata_i[int'(w_sel)*BusWidth +: BusWidth] : '0;
  assign master_be_o    = master_req_o ? be_i[int'(w_sel)*BeW +: BeW] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_lock_port <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      if (w_fire) r_rr_ptr <= wrap_port(int'(w_sel) + 1);
      if (w_issue) r_lock <= !master_gnt_i;
      else if (r_lock && !req_i[r_lock_port]) r_lock <= 1'b0;
      if (w_issue && !master_gnt_i) r_lock_port <= w_sel;
      if (w_fire) r_wptr <= next_ptr(r_wptr);
      if (w_pop) r_rptr <= next_ptr(r_rptr);
      r_count <= r_count + CntW'(w_fire) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fire) r_ids[r_wptr] <= w_sel;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_valid_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_fire && w_full));
  assert property (@(posedge clk_i) disable iff (!rst_ni) master_r_valid_i |-> (r_count != '0))
    else $warning("dm_bus_arbiter: response with no outstanding transaction dropped");
  assert property (@(posedge clk_i) disable iff (!rst_ni) r_lock |-> req_i[r_lock_port])
    else $warning("dm_bus_arbiter: locked request withdrawn before grant");
  assert property (@(posedge clk_i) (BusWidth == 32) || (BusWidth == 64));
`endif
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: vector table plus response scoreboard for dm_bus_arbiter
module tb_dm_bus_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_i, we_i, gnt_o, r_valid_o;
  logic [63:0] add_i, wdata_i;
  logic [7:0]  be_i;
  logic [31:0] r_rdata_o, master_add_o, master_wdata_o, master_r_rdata_i;
  logic [3:0]  master_be_o;
  logic        master_req_o, master_we_o, master_gnt_i, master_r_valid_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic        mgnt, mrv;
    logic [31:0] rd;
    logic [1:0]  eg;
    logic        emr;
    int          sp;
  } vec_t;

  vec_t        tv [19];
  int          q [$];
  logic [1:0]  exp_rv;
  logic [31:0] wd [2];
  logic [3:0]  bv [2];

  dm_bus_arbiter #(.NrPorts(2), .BusWidth(32), .MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .master_req_o(master_req_o), .master_add_o(master_add_o),
    .master_we_o(master_we_o), .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic expect_rvalid(input string nm);
    exp_rv = 2'b00;
    if (master_r_valid_i && q.size() > 0) exp_rv = 2'b01 << q.pop_front();
    chk(nm, 64'(r_valid_o), 64'(exp_rv));
  endtask

  initial begin
    tv[0]  = '{2'b10, 32'h0,  32'h1000, 1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 1};
    tv[1]  = '{2'b00, 32'h0,  32'h1000, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 0};
    tv[2]  = '{2'b00, 32'h0,  32'h1000, 1'b0, 1'b1, 32'hDEADBEEF, 2'b00, 1'b0, 0};
    tv[3]  = '{2'b11, 32'hA0, 32'hB0,   1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 0};
    tv[4]  = '{2'b11, 32'hA0, 32'hB0,   1'b1, 1'b1, 32'h11,       2'b10, 1'b1, 1};
    tv[5]  = '{2'b11, 32'hA0, 32'hB0,   1'b1, 1'b1, 32'h22,       2'b01, 1'b1, 0};
    tv[6]  = '{2'b11, 32'hA0, 32'hB0,   1'b1, 1'b1, 32'h33,       2'b10, 1'b1, 1};
    tv[7]  = '{2'b00, 32'hA0, 32'hB0,   1'b0, 1'b1, 32'h44,       2'b00, 1'b0, 0};
    tv[8]  = '{2'b01, 32'hC0, 32'hD0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 0};
    tv[9]  = '{2'b11, 32'hC0, 32'hD0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 0};
    tv[10] = '{2'b11, 32'hC0, 32'hD0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 0};
    tv[11] = '{2'b11, 32'hC0, 32'hD0,   1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 0};
    tv[12] = '{2'b10, 32'hC0, 32'hD0,   1'b1, 1'b0, 32'h0,        2'b10, 1'b1, 1};
    tv[13] = '{2'b11, 32'hC0, 32'hD0,   1'b1, 1'b0, 32'h0,        2'b00, 1'b0, 0};
    tv[14] = '{2'b11, 32'hC0, 32'hD0,   1'b1, 1'b1, 32'h55,       2'b00, 1'b0, 0};
    tv[15] = '{2'b11, 32'hC0, 32'hD0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 0};
    tv[16] = '{2'b11, 32'hC0, 32'hD0,   1'b1, 1'b0, 32'h0,        2'b01, 1'b1, 0};
    tv[17] = '{2'b10, 32'hC0, 32'hD0,   1'b0, 1'b1, 32'h66,       2'b00, 1'b0, 0};
    tv[18] = '{2'b10, 32'hC0, 32'hD0,   1'b0, 1'b0, 32'h0,        2'b00, 1'b1, 1};
    wd[0] = 32'h0101_0101;
    wd[1] = 32'h0202_0202;
    bv[0] = 4'h3;
    bv[1] = 4'hC;
    we_i = 2'b10;
    wdata_i = {wd[1], wd[0]};
    be_i = {bv[1], bv[0]};
    rst_ni = 1'b0;
    req_i = 2'b00;
    add_i = '0;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b0;
    master_r_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset master_req", 64'(master_req_o), 64'(0));
    chk("reset gnt", 64'(gnt_o), 64'(0));
    chk("reset r_valid", 64'(r_valid_o), 64'(0));
    rst_ni = 1'b1;
    for (int i = 0; i < 19; i++) begin
      req_i = tv[i].req;
      add_i = {tv[i].a1, tv[i].a0};
      master_gnt_i = tv[i].mgnt;
      master_r_valid_i = tv[i].mrv;
      master_r_rdata_i = tv[i].rd;
      #4;
      chk($sformatf("v%0d gnt", i), 64'(gnt_o), 64'(tv[i].eg));
      chk($sformatf("v%0d master_req", i), 64'(master_req_o), 64'(tv[i].emr));
      chk($sformatf("v%0d master_add", i), 64'(master_add_o),
          64'(tv[i].emr ? (tv[i].sp == 1 ? tv[i].a1 : tv[i].a0) : 32'h0));
      chk($sformatf("v%0d master_we", i), 64'(master_we_o), 64'(tv[i].emr && we_i[tv[i].sp]));
      chk($sformatf("v%0d master_wdata", i), 64'(master_wdata_o), 64'(tv[i].emr ? wd[tv[i].sp] : 32'h0));
      chk($sformatf("v%0d master_be", i), 64'(master_be_o), 64'(tv[i].emr ? bv[tv[i].sp] : 4'h0));
      chk($sformatf("v%0d r_rdata", i), 64'(r_rdata_o), 64'(tv[i].rd));
      expect_rvalid($sformatf("v%0d r_valid", i));
      if (tv[i].eg != 2'b00) q.push_back(tv[i].eg[1] ? 1 : 0);
      @(posedge clk_i);
      #1;
    end
    req_i = 2'b11;
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h77;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async reset master_req", 64'(master_req_o), 64'(0));
    chk("async reset gnt", 64'(gnt_o), 64'(0));
    chk("async reset r_valid", 64'(r_valid_o), 64'(0));
    chk("async reset master_add", 64'(master_add_o), 64'(0));
    chk("async reset master_we", 64'(master_we_o), 64'(0));
    chk("async reset r_rdata", 64'(r_rdata_o), 64'(0));
    q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    req_i = 2'b00;
    master_r_rdata_i = 32'h88;
    #4;
    chk("stray r_valid", 64'(r_valid_o), 64'(0));
    chk("stray r_rdata", 64'(r_rdata_o), 64'h88);
    @(posedge clk_i);
    #1;
    master_r_valid_i = 1'b0;
    req_i = 2'b11;
    master_gnt_i = 1'b1;
    #4;
    chk("post-reset gnt", 64'(gnt_o), 64'(2'b01));
    chk("post-reset master_add", 64'(master_add_o), 64'hC0);
    q.push_back(0);
    @(posedge clk_i);
    #1;
    req_i = 2'b00;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h99;
    #4;
    expect_rvalid("post-reset r_valid");
    chk("post-reset r_rdata", 64'(r_rdata_o), 64'h99);
    @(posedge clk_i);
    #1;
    master_r_valid_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
